// File: rtl/imm_gen_stream.sv
// RISC-V immediate generator with a valid/ready stream interface.
// A 2-entry (output + skid) buffer lets decode stall without losing instructions.
module imm_gen_stream #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_out,
   output logic [2:0]       imm_fmt,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam bit Is64 = (XLEN == 64);

   typedef enum logic [2:0] {
      FmtNone    = 3'd0,
      FmtI       = 3'd1,
      FmtS       = 3'd2,
      FmtB       = 3'd3,
      FmtU       = 3'd4,
      FmtJ       = 3'd5,
      FmtShamt   = 3'd6,
      FmtIllegal = 3'd7
   } fmt_e;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_sh32;
   logic [XLEN-1:0] dec_imm;
   fmt_e            dec_fmt;
   logic            dec_ill;

   assign opcode   = inst_code[6:0];
   assign funct3   = inst_code[14:12];
   assign imm_i    = XLEN'($signed(inst_code[31:20]));
   assign imm_s    = XLEN'($signed({inst_code[31:25], inst_code[11:7]}));
   assign imm_b    = XLEN'($signed({inst_code[31], inst_code[7], inst_code[30:25],
                                    inst_code[11:8], 1'b0}));
   assign imm_u    = XLEN'($signed({inst_code[31:12], 12'b0}));
   assign imm_j    = XLEN'($signed({inst_code[31], inst_code[19:12], inst_code[20],
                                    inst_code[30:21], 1'b0}));
   assign imm_sh   = Is64 ? XLEN'(inst_code[25:20]) : XLEN'(inst_code[24:20]);
   assign imm_sh32 = XLEN'(inst_code[24:20]);

   always_comb begin
      dec_imm = '0;
      dec_fmt = FmtNone;
      dec_ill = 1'b0;
      case (opcode)
         7'b0000011, 7'b1100111: begin
            dec_imm = imm_i;
            dec_fmt = FmtI;
         end
         7'b0010011: begin
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec_imm = imm_sh;
               dec_fmt = FmtShamt;
            end else begin
               dec_imm = imm_i;
               dec_fmt = FmtI;
            end
         end
         7'b0011011: begin
            if (!Is64) begin
               dec_fmt = FmtIllegal;
               dec_ill = 1'b1;
            end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec_imm = imm_sh32;
               dec_fmt = FmtShamt;
            end else begin
               dec_imm = imm_i;
               dec_fmt = FmtI;
            end
         end
         7'b0100011: begin
            dec_imm = imm_s;
            dec_fmt = FmtS;
         end
         7'b1100011: begin
            dec_imm = imm_b;
            dec_fmt = FmtB;
         end
         7'b0110111, 7'b0010111: begin
            dec_imm = imm_u;
            dec_fmt = FmtU;
         end
         7'b1101111: begin
            dec_imm = imm_j;
            dec_fmt = FmtJ;
         end
         7'b0110011, 7'b0001111, 7'b1110011: dec_fmt = FmtNone;
         7'b0111011: begin
            if (!Is64) begin
               dec_fmt = FmtIllegal;
               dec_ill = 1'b1;
            end
         end
         default: begin
            dec_fmt = FmtIllegal;
            dec_ill = 1'b1;
         end
      endcase
   end

   logic             or_valid_q, or_valid_d;
   logic [XLEN-1:0]  or_imm_q, or_imm_d;
   logic [2:0]       or_fmt_q, or_fmt_d;
   logic             or_ill_q, or_ill_d;
   logic             sk_valid_q, sk_valid_d;
   logic [XLEN-1:0]  sk_imm_q, sk_imm_d;
   logic [2:0]       sk_fmt_q, sk_fmt_d;
   logic             sk_ill_q, sk_ill_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, or_free;

   // in_ready is a pure function of the skid flop, so it is glitch-free and registered.
   assign in_ready = !sk_valid_q;
   assign accept   = in_valid && in_ready;
   assign or_free  = !or_valid_q || out_ready;

   always_comb begin
      or_valid_d = or_valid_q;
      or_imm_d   = or_imm_q;
      or_fmt_d   = or_fmt_q;
      or_ill_d   = or_ill_q;
      sk_valid_d = sk_valid_q;
      sk_imm_d   = sk_imm_q;
      sk_fmt_d   = sk_fmt_q;
      sk_ill_d   = sk_ill_q;
      cnt_d      = cnt_q;
      if (or_free) begin
         if (sk_valid_q) begin
            or_valid_d = 1'b1;
            or_imm_d   = sk_imm_q;
            or_fmt_d   = sk_fmt_q;
            or_ill_d   = sk_ill_q;
            sk_valid_d = 1'b0;
         end else if (accept) begin
            or_valid_d = 1'b1;
            or_imm_d   = dec_imm;
            or_fmt_d   = dec_fmt;
            or_ill_d   = dec_ill;
         end else begin
            or_valid_d = 1'b0;
         end
      end else if (accept) begin
         sk_valid_d = 1'b1;
         sk_imm_d   = dec_imm;
         sk_fmt_d   = dec_fmt;
         sk_ill_d   = dec_ill;
      end
      if (accept && dec_ill && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         or_valid_q <= 1'b0;
         or_imm_q   <= '0;
         or_fmt_q   <= FmtNone;
         or_ill_q   <= 1'b0;
         sk_valid_q <= 1'b0;
         sk_imm_q   <= '0;
         sk_fmt_q   <= FmtNone;
         sk_ill_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         or_valid_q <= or_valid_d;
         or_imm_q   <= or_imm_d;
         or_fmt_q   <= or_fmt_d;
         or_ill_q   <= or_ill_d;
         sk_valid_q <= sk_valid_d;
         sk_imm_q   <= sk_imm_d;
         sk_fmt_q   <= sk_fmt_d;
         sk_ill_q   <= sk_ill_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid   = or_valid_q;
   assign imm_out     = or_imm_q;
   assign imm_fmt     = or_fmt_q;
   assign illegal     = or_ill_q;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_stream.sv
// Directed bench: three instances (RV32, RV64, RV32 with 2-bit counter) share one input stream.
module tb_imm_gen_stream;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] inst_code;

   logic        rdy32, ov32, ill32;
   logic [31:0] imm32;
   logic [2:0]  fmt32;
   logic [15:0] cnt32;

   logic        rdy64, ov64, ill64;
   logic [63:0] imm64;
   logic [2:0]  fmt64;
   logic [15:0] cnt64;

   logic        rdyc2, ovc2, illc2;
   logic [31:0] immc2;
   logic [2:0]  fmtc2;
   logic [1:0]  cntc2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   imm_gen_stream #(.XLEN(32), .CNT_W(16)) u_dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32), .inst_code(inst_code),
      .out_valid(ov32), .out_ready(out_ready), .imm_out(imm32), .imm_fmt(fmt32),
      .illegal(ill32), .illegal_cnt(cnt32)
   );

   imm_gen_stream #(.XLEN(64), .CNT_W(16)) u_dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64), .inst_code(inst_code),
      .out_valid(ov64), .out_ready(out_ready), .imm_out(imm64), .imm_fmt(fmt64),
      .illegal(ill64), .illegal_cnt(cnt64)
   );

   imm_gen_stream #(.XLEN(32), .CNT_W(2)) u_dut_c2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyc2), .inst_code(inst_code),
      .out_valid(ovc2), .out_ready(out_ready), .imm_out(immc2), .imm_fmt(fmtc2),
      .illegal(illc2), .illegal_cnt(cntc2)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string tag, input logic v, input logic [31:0] imm,
                        input logic [2:0] fmt, input logic ill);
      check_eq({tag, "_valid"}, 64'(ov32), 64'(v));
      check_eq({tag, "_imm"}, 64'(imm32), 64'(imm));
      check_eq({tag, "_fmt"}, 64'(fmt32), 64'(fmt));
      check_eq({tag, "_ill"}, 64'(ill32), 64'(ill));
   endtask

   task automatic chk64(input string tag, input logic [63:0] imm, input logic [2:0] fmt,
                        input logic ill);
      check_eq({tag, "_valid64"}, 64'(ov64), 64'd1);
      check_eq({tag, "_imm64"}, imm64, imm);
      check_eq({tag, "_fmt64"}, 64'(fmt64), 64'(fmt));
      check_eq({tag, "_ill64"}, 64'(ill64), 64'(ill));
   endtask

   logic [31:0] s_inst [5];
   logic [31:0] s_imm  [5];
   logic [2:0]  s_fmt  [5];

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      inst_code = 32'h0;
      #2;
      chk32("rst", 1'b0, 32'h0, 3'd0, 1'b0);
      check_eq("rst_ready", 64'(rdy32), 64'd1);
      check_eq("rst_cnt", 64'(cnt32), 64'd0);
      #10 reset = 1'b0;

      // Back-to-back stream, consumer always ready.
      s_inst = '{32'hFFF00093, 32'hFE000EE3, 32'h0080006F, 32'h123450B7, 32'h00000033};
      s_imm  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h12345000, 32'h00000000};
      s_fmt  = '{3'd1, 3'd3, 3'd5, 3'd4, 3'd0};
      step();
      for (int i = 0; i < 5; i++) begin
         inst_code = s_inst[i];
         in_valid  = 1'b1;
         step();
         chk32($sformatf("stream%0d", i), 1'b1, s_imm[i], s_fmt[i], 1'b0);
      end
      in_valid = 1'b0;
      step();
      check_eq("stream_idle", 64'(ov32), 64'd0);
      check_eq("stream_cnt", 64'(cnt32), 64'd0);

      // RV64 / RV32 format differences and illegal counting.
      in_valid  = 1'b1;
      inst_code = 32'h800000B7;
      step();
      chk64("lui_neg", 64'hFFFFFFFF80000000, 3'd4, 1'b0);
      chk32("lui_neg32", 1'b1, 32'h80000000, 3'd4, 1'b0);
      inst_code = 32'h03F09093;
      step();
      chk64("slli63", 64'd63, 3'd6, 1'b0);
      chk32("slli63_32", 1'b1, 32'd31, 3'd6, 1'b0);
      inst_code = 32'h0000001B;
      step();
      chk64("addiw", 64'd0, 3'd1, 1'b0);
      chk32("addiw32", 1'b1, 32'd0, 3'd7, 1'b1);
      check_eq("cnt32_1", 64'(cnt32), 64'd1);
      inst_code = 32'h0000007F;
      step();
      chk32("op7f", 1'b1, 32'd0, 3'd7, 1'b1);
      check_eq("cnt32_2", 64'(cnt32), 64'd2);
      check_eq("cnt64_1", 64'(cnt64), 64'd1);
      check_eq("ill64_7f", 64'(ill64), 64'd1);
      in_valid = 1'b0;
      step();

      // Saturation of the 2-bit counter.
      #3 reset = 1'b1;
      #2 reset = 1'b0;
      check_eq("cnt_after_rst", 64'(cntc2), 64'd0);
      inst_code = 32'h0000007F;
      in_valid  = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         check_eq($sformatf("sat_c2_%0d", i), 64'(cntc2), 64'((i > 3) ? 3 : i));
         check_eq($sformatf("sat_c32_%0d", i), 64'(cnt32), 64'(i));
      end
      in_valid = 1'b0;
      step();

      // Backpressure: two accepted, then stall, then drain in order.
      #3 reset = 1'b1;
      #2 reset = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      inst_code = 32'h00100093;
      step();
      chk32("bp_a", 1'b1, 32'd1, 3'd1, 1'b0);
      check_eq("bp_rdy_a", 64'(rdy32), 64'd1);
      inst_code = 32'h00200093;
      step();
      chk32("bp_b_hold", 1'b1, 32'd1, 3'd1, 1'b0);
      check_eq("bp_rdy_b", 64'(rdy32), 64'd0);
      inst_code = 32'h00300093;
      for (int i = 0; i < 3; i++) begin
         step();
         chk32($sformatf("bp_stall%0d", i), 1'b1, 32'd1, 3'd1, 1'b0);
         check_eq($sformatf("bp_rdy_stall%0d", i), 64'(rdy32), 64'd0);
      end
      out_ready = 1'b1;
      step();
      chk32("bp_out_b", 1'b1, 32'd2, 3'd1, 1'b0);
      check_eq("bp_rdy_rel", 64'(rdy32), 64'd1);
      step();
      chk32("bp_out_c", 1'b1, 32'd3, 3'd1, 1'b0);
      inst_code = 32'h00400093;
      step();
      chk32("bp_out_d", 1'b1, 32'd4, 3'd1, 1'b0);
      in_valid = 1'b0;
      step();
      check_eq("bp_empty", 64'(ov32), 64'd0);

      // Asynchronous reset with both buffer entries full.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      inst_code = 32'h00600093;
      step();
      inst_code = 32'h00700093;
      step();
      in_valid = 1'b0;
      check_eq("pre_rst_rdy", 64'(rdy32), 64'd0);
      #2 reset = 1'b1;
      #1;
      check_eq("arst_valid", 64'(ov32), 64'd0);
      check_eq("arst_ready", 64'(rdy32), 64'd1);
      check_eq("arst_imm", 64'(imm32), 64'd0);
      #2 reset = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq($sformatf("post_rst_idle%0d", i), 64'(ov32), 64'd0);
      end
      in_valid  = 1'b1;
      inst_code = 32'h00500093;
      step();
      chk32("post_rst_new", 1'b1, 32'd5, 3'd1, 1'b0);
      in_valid = 1'b0;
      step();
      check_eq("post_rst_done", 64'(ov32), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_gen_stream.md
Name: imm_gen_stream

Overview:
- Registered, parametrised immediate generator for the RISC-V decode stage, placed between fetch/IR and the decode/ALU-operand path.
- Decodes the immediate for every base RV32I/RV64I format: I, S, B, U, J and shift-amount, including JALR, AUIPC, JAL and OP-IMM-32.
- Adds a valid/ready handshake with a 2-entry skid buffer, so decode can stall without dropping instructions.
- Adds a format tag, an illegal-opcode flag and a saturating illegal-opcode counter.

Parameters:
- XLEN, 32, immediate/output width; legal values 32 or 64.
- CNT_W, 16, width of the illegal-opcode counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  inst_code is valid this cycle
- in_ready  out  1  block can accept an instruction
- inst_code  in  32  instruction word
- out_valid  out  1  imm_out/imm_fmt/illegal are valid
- out_ready  in  1  consumer accepts the output
- imm_out  out  XLEN  sign-/zero-extended immediate
- imm_fmt  out  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT, 7=ILLEGAL
- illegal  out  1  opcode not recognised
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Decode (combinational, on inst_code[6:0]). "sext" means sign-extend to XLEN.
  - 0000011 LOAD, 1100111 JALR: I-format; imm = sext(inst[31:20]).
  - 0010011 OP-IMM:
    - funct3 001 or 101: SHAMT-format; imm = zero-extended inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64).
    - otherwise: I-format; imm = sext(inst[31:20]).
  - 0011011 OP-IMM-32: decoded like OP-IMM, but shamt is always inst[24:20]. Legal only when XLEN=64; when XLEN=32 it is ILLEGAL.
  - 0100011 STORE: S-format; imm = sext({inst[31:25], inst[11:7]}).
  - 1100011 BRANCH: B-format; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - 0110111 LUI, 0010111 AUIPC: U-format; imm = sext({inst[31:12], 12'b0}). Bit 31 is replicated up to XLEN-1.
  - 1101111 JAL: J-format; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - 0110011 OP, 0111011 OP-32 (OP-32 only when XLEN=64), 0001111 FENCE, 1110011 SYSTEM: R/none; imm = 0; illegal = 0.
  - Any other opcode: imm = 0, imm_fmt = 7, illegal = 1.
- Handshake and buffering:
  - Transfer occurs when valid and ready are both high on a rising edge.
  - Output register (OR) plus skid register (SK).
  - in_ready is registered and equals !SK.valid.
  - Latency: an accepted instruction appears on the outputs at the next rising edge when OR is empty or draining; full throughput of 1 instruction per cycle.
  - OR empty or draining this cycle: the input is written into OR.
  - OR holding and out_ready = 0: the input is written into SK; in_ready falls the next cycle.
  - OR drains while SK is full: SK moves into OR and SK empties.
  - Ordering is strictly FIFO. No drop, no duplicate.
  - Outputs are stable while out_valid = 1 and out_ready = 0.
  - in_valid while in_ready = 0: the input is ignored and is not counted.
- illegal_cnt:
  - Increments by 1 on each accepted instruction whose decode is illegal.
  - Saturates at 2^CNT_W - 1; no wrap.
- Reset (asynchronous, at any time including mid-stream):
  - OR and SK are invalidated; any in-flight instructions are discarded.
  - out_valid = 0, imm_out = 0, imm_fmt = 0, illegal = 0, illegal_cnt = 0, in_ready = 1.
  - First accept is possible on the first rising edge after reset deasserts.

Test Plan:
- XLEN=32, out_ready=1: stream 0xFFF00093 (addi -1), 0xFE000EE3 (beq -4), 0x0080006F (jal +8), 0x123450B7 (lui).
  - Required: one cycle later, back-to-back, imm_out = 0xFFFFFFFF/1, 0xFFFFFFFC/3, 0x00000008/5, 0x12345000/4 (value/imm_fmt).
- XLEN=64:
  - 0x800000B7 -> imm_out = 0xFFFFFFFF80000000, imm_fmt 4.
  - 0x03F09093 (slli 63) -> imm_out = 63, imm_fmt 6.
  - 0x0000001B -> legal, imm_fmt 1.
- XLEN=32: 0x0000001B and 0x0000007F -> illegal = 1, imm_fmt = 7, imm_out = 0, illegal_cnt 0→1→2.
- CNT_W=2: 5 consecutive illegal instructions -> illegal_cnt sticks at 3.
- Backpressure: out_ready=0 while 4 instructions are offered.
  - Required: 2 accepted, in_ready = 0 from the cycle after the 2nd accept; outputs held stable.
  - Release out_ready: all 4 emerge in order with no loss or duplicate.
- Reset asserted mid-cycle with OR and SK full:
  - Required: out_valid and in_ready react immediately, without waiting for clk.
  - Required: after deassert, the previously buffered instructions never appear.
